// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with a valid/ready ratio port.
// Ratio changes and stops take effect only at period boundaries, so the divided output never glitches.
module clk_div_ctrl #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_cfg_valid,
  input  logic [W-1:0] i_cfg_div,
  output logic         o_cfg_ready,
  output logic         o_cfg_err,
  output logic         o_div_clk,
  output logic         o_tick,
  output logic         o_busy,
  output logic [W-1:0] o_ratio
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]   state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] ratio_nxt;
  logic [W-1:0] pend, pend_nxt;
  logic         pend_vld, pend_vld_nxt;
  logic         div_nxt;
  logic         accept, legal, wrap;

  assign o_cfg_ready = (state == S_IDLE) || (state == S_RUN);
  assign accept      = i_cfg_valid && o_cfg_ready;
  assign legal       = i_cfg_div >= W'(2);
  assign wrap        = cnt == (o_ratio - W'(1));
  assign o_busy      = state != S_IDLE;
  assign o_tick      = o_busy && (cnt == '0);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ratio_nxt    = o_ratio;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    if (state == S_IDLE) begin
      cnt_nxt = '0;
      if (accept && legal) ratio_nxt = i_cfg_div;
      if (i_en) state_nxt = S_RUN;
    end else begin
      cnt_nxt = wrap ? '0 : cnt + W'(1);
      // Only a ratio pending before this cycle may apply; one accepted on a wrap waits a period.
      if (wrap && pend_vld) begin
        ratio_nxt    = pend;
        pend_vld_nxt = 1'b0;
      end
      case (state)
        S_RUN: begin
          if (accept && legal) begin
            pend_nxt     = i_cfg_div;
            pend_vld_nxt = 1'b1;
            state_nxt    = S_PEND;
          end
          if (!i_en) state_nxt = S_STOP;
        end
        S_PEND: begin
          if (!i_en)     state_nxt = S_STOP;
          else if (wrap) state_nxt = S_RUN;
        end
        default: begin
          if (wrap) state_nxt = S_IDLE;
        end
      endcase
    end
    div_nxt = (state_nxt != S_IDLE) && (cnt_nxt < (ratio_nxt >> 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      o_ratio   <= W'(3);
      pend      <= '0;
      pend_vld  <= 1'b0;
      o_div_clk <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_ratio   <= ratio_nxt;
      pend      <= pend_nxt;
      pend_vld  <= pend_vld_nxt;
      o_div_clk <= div_nxt;
      o_cfg_err <= accept && !legal;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: period-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clk_div_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       en = 1'b0, cv = 1'b0;
  logic [7:0] cd = '0;
  logic       o_cfg_ready, o_cfg_err, o_div_clk, o_tick, o_busy;
  logic [7:0] o_ratio;

  int errors = 0, checks = 0;

  // mode 0 idle, 1 running, 2 stopping; pos = place within current period
  int m_mode, m_pos, m_ratio, m_pend;
  bit m_err;

  clk_div_ctrl #(.W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(en), .i_cfg_valid(cv), .i_cfg_div(cd),
    .o_cfg_ready(o_cfg_ready), .o_cfg_err(o_cfg_err), .o_div_clk(o_div_clk),
    .o_tick(o_tick), .o_busy(o_busy), .o_ratio(o_ratio)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_mode == 0 || (m_mode == 1 && m_pend < 0);
  endfunction

  task automatic model_upd();
    bit acc;
    int om, op, d;
    if (i_rst) begin
      m_mode = 0; m_pos = 0; m_ratio = 3; m_pend = -1; m_err = 0;
      return;
    end
    d = int'(cd);
    acc = cv && m_ready();
    m_err = acc && d < 2;
    om = m_mode; op = m_pend;
    if (om == 0) begin
      if (acc && d >= 2) m_ratio = d;
      if (en) begin m_mode = 1; m_pos = 0; end
    end else begin
      if (acc && d >= 2) m_pend = d;
      if (m_pos == m_ratio - 1) begin
        m_pos = 0;
        if (op >= 0) begin m_ratio = op; m_pend = -1; end
        if (om == 2) m_mode = 0;
      end else m_pos++;
      if (om == 1 && !en) m_mode = 2;
    end
  endtask

  task automatic cmp_all();
    chk("busy",  o_busy,      m_mode != 0);
    chk("tick",  o_tick,      m_mode != 0 && m_pos == 0);
    chk("div",   o_div_clk,   m_mode != 0 && m_pos < m_ratio / 2);
    chk("ready", o_cfg_ready, m_ready());
    chk("ratio", o_ratio,     m_ratio);
    chk("err",   o_cfg_err,   m_err);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_upd();
    @(negedge i_clk);
    cmp_all();
  endtask

  task automatic run_pat(input string nm, input int n, input int pat);
    // pat bit (n-1-k) is the expected o_div_clk in cycle k of the period
    for (int k = 0; k < 2 * n; k++) begin
      chk(nm, o_div_clk, (pat >> (n - 1 - (k % n))) & 1);
      cyc();
    end
  endtask

  initial begin
    model_upd();
    repeat (3) cyc();
    i_rst = 1'b0;
    cyc();
    chk("rst_ratio", o_ratio, 3);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_cfg_ready, 1);
    chk("rst_div", o_div_clk, 0);

    // default ratio 3 -> 1,0,0 with tick on each high
    en = 1'b1;
    cyc();
    chk("first_tick", o_tick, 1);
    run_pat("n3_pat", 3, 3'b100);

    // back to idle, load 4, then 1,1,0,0
    en = 1'b0;
    for (int k = 0; k < 20 && m_mode != 0; k++) cyc();
    chk("to_idle", o_busy, 0);
    cv = 1'b1; cd = 8'd4;
    cyc();
    cv = 1'b0;
    chk("idle_load4", o_ratio, 4);
    en = 1'b1;
    cyc();
    run_pat("n4_pat", 4, 4'b1100);

    // return to 3, then offer 6 at cnt=1
    cv = 1'b1; cd = 8'd3;
    cyc();
    cv = 1'b0;
    for (int k = 0; k < 20 && !(m_ratio == 3 && m_pos == 1); k++) cyc();
    chk("at_n3_cnt1", o_ratio, 3);
    cv = 1'b1; cd = 8'd6;
    cyc();
    cv = 1'b0;
    chk("pend_div", o_div_clk, 0);
    chk("pend_ready", o_cfg_ready, 0);
    chk("pend_ratio", o_ratio, 3);
    cyc();
    chk("switch_ratio", o_ratio, 6);
    chk("switch_ready", o_cfg_ready, 1);
    run_pat("n6_pat", 6, 6'b111000);

    // illegal ratio 1
    cyc(); cyc();
    cv = 1'b1; cd = 8'd1;
    cyc();
    cv = 1'b0;
    chk("err_pulse", o_cfg_err, 1);
    chk("err_ratio", o_ratio, 6);
    cyc();
    chk("err_clear", o_cfg_err, 0);

    // ratio 5, drop enable at cnt=0
    cv = 1'b1; cd = 8'd5;
    cyc();
    cv = 1'b0;
    for (int k = 0; k < 30 && !(m_ratio == 5 && m_pos == 0); k++) cyc();
    chk("n5_tick", o_tick, 1);
    en = 1'b0;
    repeat (4) cyc();
    chk("stop_busy", o_busy, 1);
    cyc();
    chk("stop_idle", o_busy, 0);
    chk("stop_div", o_div_clk, 0);

    // async reset while a ratio is pending
    en = 1'b1;
    repeat (3) cyc();
    cv = 1'b1; cd = 8'd7;
    cyc();
    cv = 1'b0;
    chk("pre_rst_ready", o_cfg_ready, 0);
    #1 i_rst = 1'b1;
    #1;
    model_upd();
    chk("arst_div", o_div_clk, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_tick", o_tick, 0);
    chk("arst_ratio", o_ratio, 3);
    cyc();
    i_rst = 1'b0;
    cyc();
    chk("post_rst_ready", o_cfg_ready, 1);
    repeat (20) cyc();
    chk("pend_discard", o_ratio, 3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 8) en = ~en;
      cv = ($urandom_range(0, 99) < 20);
      cd = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      i_rst = ($urandom_range(0, 999) < 3);
      cyc();
    end
    i_rst = 1'b0;
    cv = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter: W, default 8, width of the divide ratio and cycle counter.
REQ-002 SHALL have port: i_clk  input  1  sole clock, all logic on its rising edge.
REQ-003 SHALL have port: i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: i_en  input  1  level run-enable for the divided clock.
REQ-005 SHALL have port: i_cfg_valid  input  1  new divide ratio offered.
REQ-006 SHALL have port: i_cfg_div  input  W  offered divide ratio N.
REQ-007 SHALL have port: o_cfg_ready  output  1  controller can accept a ratio this cycle.
REQ-008 SHALL have port: o_cfg_err  output  1  one-cycle pulse, accepted ratio was illegal.
REQ-009 SHALL have port: o_div_clk  output  1  registered divided clock.
REQ-010 SHALL have port: o_tick  output  1  high in the first i_clk cycle of each divided period.
REQ-011 SHALL have port: o_busy  output  1  high when not IDLE.
REQ-012 SHALL have port: o_ratio  output  W  ratio currently in effect.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PEND (new ratio pending) and STOP (disable pending).
REQ-014 SHALL count with cnt over 0..N-1 in RUN, PEND and STOP, wrapping from N-1 to 0.
REQ-015 SHALL define H = N>>1 and drive o_div_clk = 1 when cnt < H and 0 otherwise, registered alongside cnt (N=3: 1 high, 2 low; N=4: 2 high, 2 low).
REQ-016 SHALL assert o_tick when cnt==0 and the state is not IDLE.
REQ-017 SHALL accept a ratio only on a cycle where i_cfg_valid and o_cfg_ready are both high.
REQ-018 SHALL drive o_cfg_ready high in IDLE and RUN, and low in PEND and STOP.
REQ-019 SHALL treat legal N as 2..2^W-1.
REQ-020 SHALL handle an accepted N of 0 or 1 as follows: complete the handshake, pulse o_cfg_err the next cycle, leave o_ratio unchanged and cause no state change.
REQ-021 SHALL, for a legal ratio accepted in IDLE, load o_ratio on the next edge.
REQ-022 SHALL, for a legal ratio accepted in RUN, store it, enter PEND and load it on the next wrap edge (cnt N-1 -> 0), so the new period starts with the new N.
REQ-023 SHALL, for a ratio accepted on the same cycle as a wrap, treat it as pending and apply it at the following wrap, never truncating a period.
REQ-024 SHALL move IDLE -> RUN on the edge after i_en is sampled high, with cnt=0, o_div_clk=1 and o_tick=1 in the first RUN cycle.
REQ-025 SHALL, when i_en is sampled low in RUN or PEND, enter STOP; any pending ratio is retained.
REQ-026 SHALL, in STOP, finish the current period, and on the wrap edge go to IDLE with cnt=0 and o_div_clk=0, applying any pending ratio.
REQ-027 SHALL, when i_en returns high during STOP, still complete the stop, then restart from IDLE per REQ-024.
REQ-028 SHALL, in IDLE, hold o_div_clk=0, o_tick=0 and cnt=0.
REQ-029 SHALL never produce a divided high or low phase shorter than that defined by the ratio in effect for that period (glitch-free ratio change).

Reset
REQ-030 SHALL, while i_rst is high, asynchronously force state=IDLE, cnt=0, o_ratio=3, pending cleared, o_div_clk=0, o_tick=0, o_cfg_err=0 and o_busy=0.
REQ-031 SHALL, on reset asserted mid-period, abort the period immediately with no completion and discard any pending ratio.
REQ-032 SHALL make o_cfg_ready high in the first cycle after reset release.

Verification
REQ-033 SHALL be tested with: reset, i_en=1 with default ratio -> o_div_clk pattern 1,0,0 repeating, and o_tick on each 1.
REQ-034 SHALL be tested with: in IDLE, cfg N=4 -> o_ratio=4 next cycle; i_en=1 -> 1,1,0,0 repeating.
REQ-035 SHALL be tested with: running at N=3, cfg N=6 at cnt=1 -> current period completes as 1,0,0, then 1,1,1,0,0,0, with o_cfg_ready low until the switch.
REQ-036 SHALL be tested with: cfg N=1 -> o_cfg_err one-cycle pulse, o_ratio unchanged, output pattern undisturbed.
REQ-037 SHALL be tested with: i_en dropped at cnt=0 with N=5 -> 4 more cycles, then IDLE, o_div_clk=0 and o_busy=0.
REQ-038 SHALL be tested with: i_rst pulsed mid-PEND -> outputs zero at once, o_ratio=3, and the pending ratio is never applied.
